// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive front end.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   localparam int unsigned FRAME_DATA_BITS = 8;

   localparam int unsigned OVF_BIT   = 15;
   localparam int unsigned PERR_BIT  = 14;
   localparam int unsigned COUNT_LSB = 8;

endpackage

// File: rtl/ps2_rx_fifo_byte_fifo.sv
// Small circular byte buffer; a pop frees its slot for a push in the same cycle.
module byte_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [FRAME_DATA_BITS-1:0] din,
   input  logic                       pop,
   output logic [FRAME_DATA_BITS-1:0] dout,
   output logic [3:0]                 count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

   logic [FRAME_DATA_BITS-1:0] r_mem [DEPTH];
   logic [AW-1:0]              r_wptr;
   logic [AW-1:0]              r_rptr;
   logic [3:0]                 r_count;
   logic                       w_pop;
   logic                       w_push;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + AW'(1);
   endfunction

   assign empty  = (r_count == 4'd0);
   assign full   = (r_count == 4'(DEPTH));
   assign w_pop  = pop & ~empty;
   assign w_push = push & (~full | w_pop);
   assign count  = r_count;
   assign dout   = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= ptr_inc(r_wptr);
         if (w_pop)  r_rptr <= ptr_inc(r_rptr);
         r_count <= r_count + {3'd0, w_push} - {3'd0, w_pop};
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host deframer with parity check, watchdog and byte FIFO;
// presents FIFO head, count and sticky error flags as one bus word.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned TIMEOUT    = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2clk,
   input  logic        ps2data,
   input  logic        rd,
   output logic [31:0] out,
   output logic        irq
);

   localparam int unsigned WDW = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
   localparam int unsigned BCW = $clog2(FRAME_DATA_BITS);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_DATA_BITS - 1);

   logic r_clk_s1, r_clk_s2, r_clk_prev;
   logic r_dat_s1, r_dat_s2;
   ps2_state_t r_state, w_state_nxt;
   logic [FRAME_DATA_BITS-1:0] r_shift;
   logic [BCW-1:0] r_bitcnt;
   logic r_par;
   logic [WDW-1:0] r_wdog;
   logic r_ovf, r_perr, r_irq;
   logic w_fall, w_timeout, w_good, w_frame_end;
   logic w_push, w_perr_set, w_drop, w_accept;
   logic w_full, w_empty;
   logic [3:0] w_count;
   logic [FRAME_DATA_BITS-1:0] w_dout;

   // Synchronizers idle high so reset never fabricates a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
      end else begin
         r_clk_s1   <= ps2clk;
         r_clk_s2   <= r_clk_s1;
         r_clk_prev <= r_clk_s2;
         r_dat_s1   <= ps2data;
         r_dat_s2   <= r_dat_s1;
      end
   end

   assign w_fall      = r_clk_prev & ~r_clk_s2;
   assign w_timeout   = (r_state != ST_IDLE) & ~w_fall & (r_wdog == WD_LAST);
   assign w_good      = r_dat_s2 & (^{r_shift, r_par});
   assign w_frame_end = (r_state == ST_STOP) & w_fall;
   assign w_push      = w_frame_end & w_good;
   assign w_perr_set  = w_frame_end & ~w_good;
   // A pop in the same cycle frees a slot, so only push-on-full without rd drops.
   assign w_drop      = w_push & w_full & ~rd;
   assign w_accept    = w_push & ~w_drop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_timeout) begin
         w_state_nxt = ST_IDLE;
      end else if (w_fall) begin
         unique case (r_state)
            ST_IDLE:   if (!r_dat_s2) w_state_nxt = ST_DATA;
            ST_DATA:   if (r_bitcnt == BIT_LAST) w_state_nxt = ST_PARITY;
            ST_PARITY: w_state_nxt = ST_STOP;
            ST_STOP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift  <= '0;
         r_bitcnt <= '0;
         r_par    <= 1'b0;
      end else if (w_fall) begin
         case (r_state)
            ST_IDLE:   r_bitcnt <= '0;
            ST_DATA: begin
               r_shift  <= {r_dat_s2, r_shift[FRAME_DATA_BITS-1:1]};
               r_bitcnt <= r_bitcnt + BCW'(1);
            end
            ST_PARITY: r_par <= r_dat_s2;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            r_wdog <= '0;
      else if (r_state == ST_IDLE || w_fall) r_wdog <= '0;
      else                                r_wdog <= r_wdog + WDW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf  <= 1'b0;
         r_perr <= 1'b0;
         r_irq  <= 1'b0;
      end else begin
         r_ovf  <= w_drop | (r_ovf & ~rd);
         r_perr <= w_perr_set | (r_perr & ~rd);
         r_irq  <= w_accept;
      end
   end

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .din   (r_shift),
      .pop   (rd),
      .dout  (w_dout),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

   always_comb begin
      out              = '0;
      out[OVF_BIT]     = r_ovf;
      out[PERR_BIT]    = r_perr;
      out[COUNT_LSB+:4] = w_count;
      out[7:0]         = w_empty ? 8'h00 : w_dout;
   end

   assign irq = r_irq;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames driven on the pins, bus word checked.
module tb_ps2_rx_fifo;

   localparam int unsigned TO = 200;
   localparam int unsigned H  = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        ps2clk;
   logic        ps2data;
   logic        rd;
   logic [31:0] out;
   logic        irq;

   int checks    = 0;
   int failures  = 0;
   int irq_cnt   = 0;
   int irq_base;

   ps2_rx_fifo #(.FIFO_DEPTH(8), .TIMEOUT(TO)) dut (
      .clk     (clk),
      .rst     (rst),
      .ps2clk  (ps2clk),
      .ps2data (ps2data),
      .rd      (rd),
      .out     (out),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (irq) irq_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One PS/2 bit: data set, half period, clock low, half period, clock high.
   task automatic ps2_bit(input logic b, input bit rd_at_fall);
      @(negedge clk);
      ps2data = b;
      repeat (H) @(negedge clk);
      ps2clk = 1'b0;
      if (rd_at_fall) begin
         @(negedge clk);
         @(negedge clk);
         rd = 1'b1;
         @(negedge clk);
         rd = 1'b0;
         check("irq_in_push_cycle", {31'd0, irq}, 32'd1);
         repeat (H - 3) @(negedge clk);
      end else begin
         repeat (H) @(negedge clk);
      end
      ps2clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip, input bit rd_stop,
                             input int pause);
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         ps2_bit(d[i], 1'b0);
         if (i == 3 && pause > 0) repeat (pause) @(negedge clk);
      end
      ps2_bit((~^d) ^ par_flip, 1'b0);
      ps2_bit(1'b1, rd_stop);
      repeat (H) @(negedge clk);
   endtask

   task automatic do_rd();
      @(negedge clk);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ps2clk = 1'b1; ps2data = 1'b1; rd = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_out", out, 32'h0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Single good frame
      irq_base = irq_cnt;
      send_frame(8'h1C, 1'b0, 1'b0, 0);
      check("good_irq_count", irq_cnt - irq_base, 1);
      check("good_out", out, 32'h0000_011C);
      do_rd();
      check("good_after_rd", out, 32'h0);

      // Bad parity
      irq_base = irq_cnt;
      send_frame(8'h1C, 1'b1, 1'b0, 0);
      check("perr_irq_count", irq_cnt - irq_base, 0);
      check("perr_out", out, 32'h0000_4000);
      do_rd();
      check("perr_cleared", out, 32'h0);

      // Overflow: ninth byte dropped
      irq_base = irq_cnt;
      for (int v = 1; v <= 9; v++) send_frame(8'(v), 1'b0, 1'b0, 0);
      check("ovf_irq_count", irq_cnt - irq_base, 8);
      check("ovf_out", out, 32'h0000_8801);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("ovf_head_%0d", i), {24'd0, out[7:0]}, 32'(i));
         do_rd();
      end
      check("ovf_drained", out, 32'h0);

      // Push and pop in the same cycle while full
      for (int v = 8'h11; v <= 8'h18; v++) send_frame(8'(v), 1'b0, 1'b0, 0);
      check("full_out", out, 32'h0000_0811);
      irq_base = irq_cnt;
      send_frame(8'h19, 1'b0, 1'b1, 0);
      check("simul_irq_count", irq_cnt - irq_base, 1);
      check("simul_out", out, 32'h0000_0812);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("simul_head_%0d", i), {24'd0, out[7:0]}, 32'(8'h12 + i));
         do_rd();
      end
      check("simul_drained", out, 32'h0);

      // Partial frame abandoned by the watchdog
      irq_base = irq_cnt;
      ps2_bit(1'b0, 1'b0);
      ps2_bit(1'b1, 1'b0);
      ps2_bit(1'b0, 1'b0);
      ps2_bit(1'b1, 1'b0);
      ps2_bit(1'b1, 1'b0);
      repeat (TO + 20) @(negedge clk);
      send_frame(8'hF0, 1'b0, 1'b0, 0);
      check("timeout_irq_count", irq_cnt - irq_base, 1);
      check("timeout_out", out, 32'h0000_01F0);
      do_rd();
      check("timeout_cleared", out, 32'h0);

      // Mid-frame stall shorter than the watchdog keeps the frame
      irq_base = irq_cnt;
      send_frame(8'hA5, 1'b0, 1'b0, TO - 2 * H - 20);
      check("stall_irq_count", irq_cnt - irq_base, 1);
      check("stall_out", out, 32'h0000_01A5);
      do_rd();

      // Reset in the middle of a frame, with a byte already queued
      send_frame(8'h33, 1'b0, 1'b0, 0);
      check("pre_reset_out", out, 32'h0000_0133);
      ps2_bit(1'b0, 1'b0);
      ps2_bit(1'b1, 1'b0);
      ps2_bit(1'b1, 1'b0);
      ps2_bit(1'b0, 1'b0);
      ps2_bit(1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midreset_out", out, 32'h0);
      check("midreset_irq", {31'd0, irq}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      irq_base = irq_cnt;
      send_frame(8'h5A, 1'b0, 1'b0, 0);
      check("postreset_irq_count", irq_cnt - irq_base, 1);
      check("postreset_out", out, 32'h0000_015A);
      do_rd();
      check("postreset_cleared", out, 32'h0);

      // Pop on empty is ignored
      do_rd();
      check("empty_pop", out, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 keyboard receive front end: samples the raw `ps2clk`/`ps2data` pins, deframes 11-bit device-to-host frames, checks parity, and buffers received scan-code bytes in a small FIFO. It is the stage directly upstream of the system bus input port that carries keyboard data. It drives one bus input word and one interrupt line to the CPU. The CPU drains the FIFO one byte per read strobe.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: byte entries; must be a power of two, ≤ 8.
- `TIMEOUT`, default 50000: idle clock cycles, with no ps2clk falling edge, before a partial frame is discarded (1 ms at 50 MHz).

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `ps2clk`  in  1: raw PS/2 clock pin; asynchronous to `clk`.
- `ps2data`  in  1: raw PS/2 data pin; asynchronous to `clk`.
- `rd`  in  1: one-cycle pop strobe from the bus.
- `out`  out  32: bit fields, MSB to LSB:
  - `16'd0`
  - `ovf` (bit 15)
  - `perr` (bit 14)
  - `2'b00` (bits 13:12)
  - `count[3:0]` (bits 11:8)
  - `head[7:0]` (bits 7:0)
- `irq`  out  1: one-cycle pulse per byte accepted into the FIFO.

## Operation
- **Input sync:** `ps2clk` and `ps2data` each pass through a 2-flop synchronizer. A falling edge is high on the previous synced sample and low on the current one.
- **Sampling:** all frame sampling uses synced `ps2data` in the cycle the falling edge is detected.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - **IDLE:** on a falling edge with data 0 (start bit), go to DATA and clear `bitcnt`. Data 1 is ignored.
  - **DATA:** shift right, inserting the new bit at [7]. Bits arrive LSB first. After the 8th bit, go to PARITY.
  - **PARITY:** latch the bit, then go to STOP.
  - **STOP:** the frame is good if data = 1 and the XOR of the 8 data bits and the parity bit = 1 (odd parity).
    - Good frame: push the byte.
    - Bad frame: set sticky `perr` and push nothing.
  - After STOP the FSM always returns to IDLE.
- **Timeout:** outside IDLE, a watchdog counts cycles since the last falling edge and is cleared on every edge. At `TIMEOUT` the FSM returns to IDLE: frame discarded, no flag set, no `irq`.
- **FIFO:**
  - `count` ranges 0..`FIFO_DEPTH`.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `head` = oldest byte, or 0x00 when empty.
- **Push when full:** the byte is dropped, sticky `ovf` is set, and there is no `irq`.
- **Pop (`rd`) when empty:** ignored; `count` stays 0.
- **Simultaneous push and pop:**
  - Pop is applied first, then push; `count` is unchanged.
  - When full, the push succeeds and `irq` pulses.
  - When empty, the pushed byte becomes `head` and `count` goes to 1.
- **Sticky flags:** `rd` clears `ovf` and `perr` (even when the FIFO is empty). A flag set in the same cycle as `rd` stays set.
- **Reset values:** `out` = 0, `irq` = 0, FSM = IDLE, pointers and `count` = 0, flags = 0, synchronizer flops = 1 (lines idle high).
- **Reset mid-frame:** the partial frame is lost and nothing is pushed.

## Timing
- **Pin to edge detect:** 3 `clk` cycles from a pin transition to internal edge detection.
- **Stop bit to FIFO:** in the cycle after the stop-bit edge is detected:
  - `irq` = 1 for exactly one cycle;
  - `count` and `head` reflect the new state in that same cycle.
- **Pop:** `rd` in cycle N updates `count`, `head` and the flags in cycle N+1.
- **Output timing:** `out` is fully registered; there are no combinational paths from `rd` to `out`.
- **Watchdog:** fires after exactly `TIMEOUT` cycles without an edge; an edge in cycle `TIMEOUT-1` keeps the frame alive.

## Structure
- Package `ps2_pkg` holds:
  - the FSM state enum (2 bits);
  - `FRAME_DATA_BITS` = 8;
  - `out` field bit positions: `OVF_BIT` = 15, `PERR_BIT` = 14, `COUNT_LSB` = 8.
- Sub-module `byte_fifo` holds the storage, pointers and count. Ports: `clk`, `rst`, `push`, `din[7:0]`, `pop`, `dout[7:0]`, `count`, `full`, `empty`.
- Top level holds the synchronizer, edge detect, FSM, watchdog, flags and `out` packing.

## Test plan
- **Single good frame:** frame 0x1C (parity 0) at 10 kHz PS/2 clock → one `irq` pulse, `out` = 0x0000011C; after `rd`, `out` = 0x00000000.
- **Bad parity:** frame 0x1C with parity 1 → no `irq`, `out[14]` = 1, `count` = 0; `rd` clears it → `out` = 0.
- **Overflow:** send 0x01..0x09 with no reads → 8 `irq`s and `count` = 8, `head` = 0x01, `ovf` = 1; eight `rd`s yield 0x01..0x08 in order; 0x09 is lost.
- **Simultaneous push and pop when full:** `rd` asserted in the exact cycle of the 9th push → `count` stays 8, `irq` pulses, the newest entry = the 9th byte, `ovf` = 0.
- **Timeout:** send start + 4 bits, stall `TIMEOUT` cycles, then a full frame 0xF0 → only 0xF0 is received, `perr` = 0.
- **Reset mid-frame:** assert `rst` after 5 bits, release, then send 0x5A → only 0x5A appears; all outputs are 0 during reset.
